// File: rtl/vector_stream_buffer.sv
// ---------------------------------------------------------------------------
// vector_stream_buffer
//
// Matrix column buffer for the QR datapath. A load frame writes NUM_VEC
// vectors of VEC_LEN elements, one element per accepted cycle, into a
// register array. Once the frame is complete, whole vectors are streamed out
// on request. The vector can be picked by a wrapping sequential pointer or by
// an explicit index, so any column can be re-read without reloading.
//
// Ports
//   clk              rising-edge clock
//   reset            synchronous, active-high reset
//   A_i              load data (one element)
//   in_valid         A_i valid this cycle; used only while loading
//   start_write      level; high opens and holds a frame, low aborts/closes it
//   start_read       request one vector; sampled only when the frame is loaded
//   rd_index_en      1: read vector rd_index, 0: read the sequential pointer
//   rd_index         vector index for indexed reads
//   A_o              streamed element; 0 when out_valid is low
//   out_valid        A_o carries an element
//   done_load        level; the whole frame is stored
//   done_read_vector one-cycle pulse with the last element of a vector
//   vec_count        complete vectors stored in the current frame
//   busy             loading or streaming
//   err_index        sticky; an indexed request named a vector >= NUM_VEC
// ---------------------------------------------------------------------------
module vector_stream_buffer #(
  parameter  int DATA_WIDTH = 16,
  parameter  int VEC_LEN    = 3,
  parameter  int NUM_VEC    = 3,
  localparam int TOTAL      = VEC_LEN * NUM_VEC,
  localparam int IDX_W      = $clog2(NUM_VEC),
  localparam int CNT_W      = $clog2(NUM_VEC + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic                  in_valid,
  input  logic                  start_write,
  input  logic                  start_read,
  input  logic                  rd_index_en,
  input  logic [IDX_W-1:0]      rd_index,
  output logic [DATA_WIDTH-1:0] A_o,
  output logic                  out_valid,
  output logic                  done_load,
  output logic                  done_read_vector,
  output logic [CNT_W-1:0]      vec_count,
  output logic                  busy,
  output logic                  err_index
);

  localparam int ADDR_W = $clog2(TOTAL);
  localparam int EW     = $clog2(VEC_LEN);
  localparam logic [IDX_W:0] NUM_VEC_EXT = (IDX_W + 1)'(NUM_VEC);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_LOADED = 2'd2,
    S_READ   = 2'd3
  } state_t;

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   mem_q [TOTAL];
  logic [ADDR_W-1:0]       wr_ptr_q;
  logic [EW-1:0]           ld_elem_q;
  logic [CNT_W-1:0]        vec_count_q;
  logic [IDX_W-1:0]        rd_seq_q;
  logic                    rd_seq_mode_q;
  logic [ADDR_W-1:0]       rd_addr_q;
  logic [EW-1:0]           rd_elem_q;
  logic [DATA_WIDTH-1:0]   a_q;
  logic                    out_valid_q;
  logic                    done_read_q;
  logic                    done_load_q;
  logic                    busy_q;
  logic                    err_index_q;

  logic [IDX_W-1:0]        sel_vec_d;
  logic [ADDR_W-1:0]       start_addr_d;
  logic                    idx_bad_d;
  logic [IDX_W-1:0]        rd_seq_d;
  logic                    mem_we_d;

  // Read request decode: chosen vector, its base address, index validity and
  // the wrapped successor of the sequential pointer.
  always_comb begin
    sel_vec_d    = rd_index_en ? rd_index : rd_seq_q;
    start_addr_d = ADDR_W'(sel_vec_d) * ADDR_W'(VEC_LEN);
    idx_bad_d    = ({1'b0, rd_index} >= NUM_VEC_EXT);
    if (rd_seq_q == IDX_W'(NUM_VEC - 1)) begin
      rd_seq_d = '0;
    end else begin
      rd_seq_d = rd_seq_q + IDX_W'(1);
    end
    // An abort (start_write low) in the same cycle discards the element.
    mem_we_d = !reset && (state_q == S_LOAD) && start_write && in_valid;
  end

  // Element storage; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem_q[wr_ptr_q] <= A_i;
    end
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      ld_elem_q     <= '0;
      vec_count_q   <= '0;
      rd_seq_q      <= '0;
      rd_seq_mode_q <= 1'b0;
      rd_addr_q     <= '0;
      rd_elem_q     <= '0;
      a_q           <= '0;
      out_valid_q   <= 1'b0;
      done_read_q   <= 1'b0;
      done_load_q   <= 1'b0;
      busy_q        <= 1'b0;
      err_index_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          a_q         <= '0;
          out_valid_q <= 1'b0;
          done_read_q <= 1'b0;
          done_load_q <= 1'b0;
          if (start_write) begin
            state_q     <= S_LOAD;
            wr_ptr_q    <= '0;
            ld_elem_q   <= '0;
            vec_count_q <= '0;
            rd_seq_q    <= '0;
            busy_q      <= 1'b1;
          end else begin
            busy_q      <= 1'b0;
          end
        end

        S_LOAD: begin
          if (!start_write) begin
            state_q     <= S_IDLE;
            vec_count_q <= '0;
            busy_q      <= 1'b0;
          end else if (in_valid) begin
            wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            // A vector counts as stored on the edge that writes its last element.
            if (ld_elem_q == EW'(VEC_LEN - 1)) begin
              ld_elem_q   <= '0;
              vec_count_q <= vec_count_q + CNT_W'(1);
            end else begin
              ld_elem_q   <= ld_elem_q + EW'(1);
            end
            if (wr_ptr_q == ADDR_W'(TOTAL - 1)) begin
              state_q     <= S_LOADED;
              done_load_q <= 1'b1;
              busy_q      <= 1'b0;
            end
          end
        end

        S_LOADED: begin
          if (!start_write) begin
            // Abort has priority over any simultaneous read request.
            state_q     <= S_IDLE;
            done_load_q <= 1'b0;
            vec_count_q <= '0;
          end else if (start_read) begin
            if (rd_index_en && idx_bad_d) begin
              err_index_q <= 1'b1;
            end else begin
              // First element goes out on this edge: one-cycle request latency.
              state_q       <= S_READ;
              busy_q        <= 1'b1;
              a_q           <= mem_q[start_addr_d];
              out_valid_q   <= 1'b1;
              done_read_q   <= 1'b0;
              rd_addr_q     <= start_addr_d + ADDR_W'(1);
              rd_elem_q     <= '0;
              rd_seq_mode_q <= !rd_index_en;
            end
          end
        end

        S_READ: begin
          if (!start_write) begin
            // Truncate the vector silently: no done pulse.
            state_q     <= S_IDLE;
            a_q         <= '0;
            out_valid_q <= 1'b0;
            done_read_q <= 1'b0;
            done_load_q <= 1'b0;
            vec_count_q <= '0;
            busy_q      <= 1'b0;
          end else if (rd_elem_q == EW'(VEC_LEN - 1)) begin
            // Last element already shown; this idle cycle is the inter-read gap.
            state_q     <= S_LOADED;
            a_q         <= '0;
            out_valid_q <= 1'b0;
            done_read_q <= 1'b0;
            busy_q      <= 1'b0;
            if (rd_seq_mode_q) begin
              rd_seq_q <= rd_seq_d;
            end
          end else begin
            a_q         <= mem_q[rd_addr_q];
            rd_addr_q   <= rd_addr_q + ADDR_W'(1);
            rd_elem_q   <= rd_elem_q + EW'(1);
            done_read_q <= (rd_elem_q == EW'(VEC_LEN - 2));
          end
        end

        default: begin
          state_q     <= S_IDLE;
          a_q         <= '0;
          out_valid_q <= 1'b0;
          done_read_q <= 1'b0;
          done_load_q <= 1'b0;
          vec_count_q <= '0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign A_o              = a_q;
  assign out_valid        = out_valid_q;
  assign done_load        = done_load_q;
  assign done_read_vector = done_read_q;
  assign vec_count        = vec_count_q;
  assign busy             = busy_q;
  assign err_index        = err_index_q;

endmodule
